// File: rtl/dm_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter.
//   state_e  : arbiter FSM state encoding
//   owner_e  : which requester currently owns the DM access
//   defaults : MEM_LAT / DM_WORDS
//   word_oob : true when a byte address falls outside the DM word range
package dm_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  typedef enum logic {
    OWN_M = 1'b0,
    OWN_B = 1'b1
  } owner_e;

  localparam int unsigned MEM_LAT_DEF  = 2;
  localparam int unsigned DM_WORDS_DEF = 4096;

  function automatic logic word_oob(input logic [31:0] addr, input int unsigned words);
    return {2'b00, addr[31:2]} >= 32'(words);
  endfunction

endpackage

// File: rtl/dm_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the data memory.
//   m_*  : pipeline Memory-stage request / response
//   b_*  : bridge/debug request / response
//   oob, busy : status
//   dm_* : single-port data memory access
// Modports: slave = arbiter side, master = requester/memory side.
interface dm_arbiter_if;
  logic        m_req;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_be;
  logic        m_done;
  logic [31:0] m_rdata;
  logic        m_stall;

  logic        b_req;
  logic        b_we;
  logic [31:0] b_addr;
  logic [31:0] b_wdata;
  logic [3:0]  b_be;
  logic        b_done;
  logic [31:0] b_rdata;

  logic        oob;
  logic        busy;

  logic        dm_en;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [3:0]  dm_be;
  logic [31:0] dm_rdata;

  modport slave (
    input  m_req, m_we, m_addr, m_wdata, m_be,
    input  b_req, b_we, b_addr, b_wdata, b_be,
    input  dm_rdata,
    output m_done, m_rdata, m_stall,
    output b_done, b_rdata,
    output oob, busy,
    output dm_en, dm_we, dm_addr, dm_wdata, dm_be
  );

  modport master (
    output m_req, m_we, m_addr, m_wdata, m_be,
    output b_req, b_we, b_addr, b_wdata, b_be,
    output dm_rdata,
    input  m_done, m_rdata, m_stall,
    input  b_done, b_rdata,
    input  oob, busy,
    input  dm_en, dm_we, dm_addr, dm_wdata, dm_be
  );
endinterface

// File: rtl/dm_arbiter_rr_arb2.sv
// Two-input round-robin grant.
//   req_i        : [0] = M request, [1] = B request
//   last_grant_i : owner of the most recently completed access
//   gnt_o        : one-hot grant (combinational), same bit order as req_i
module rr_arb2
  import dm_arbiter_pkg::*;
(
  input  logic [1:0] req_i,
  input  owner_e     last_grant_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = '0;
    case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      // tie: favour whoever was not served last
      2'b11:   gnt_o = (last_grant_i == OWN_M) ? 2'b10 : 2'b01;
      default: gnt_o = '0;
    endcase
  end

endmodule

// File: rtl/dm_arbiter.sv
// Data-memory arbiter: shares a single-port DM between the pipeline M stage
// and the bridge port, one access at a time, with a fixed DM read latency.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : dm_arbiter_if.slave (requesters, status and DM port)
module dm_arbiter
  import dm_arbiter_pkg::*;
#(
  parameter int unsigned MEM_LAT  = MEM_LAT_DEF,
  parameter int unsigned DM_WORDS = DM_WORDS_DEF
) (
  input  logic         clk,
  input  logic         reset,
  dm_arbiter_if.slave  bus
);

  state_e      state_q, state_d;
  owner_e      owner_q, last_q;
  logic        oob_q;
  logic [3:0]  cnt_q;
  logic [31:0] m_rdata_q, b_rdata_q;
  logic        dm_en_q, dm_we_q;
  logic [31:0] dm_addr_q, dm_wdata_q;
  logic [3:0]  dm_be_q;

  logic [1:0]  gnt;
  logic        sel_b;
  logic        sel_we;
  logic [31:0] sel_addr, sel_wdata;
  logic [3:0]  sel_be;
  logic        sel_oob;
  logic        m_done, b_done, oob, busy;

  rr_arb2 u_rr_arb2 (
    .req_i        ({bus.b_req, bus.m_req}),
    .last_grant_i (last_q),
    .gnt_o        (gnt)
  );

  assign sel_b     = gnt[1];
  assign sel_we    = sel_b ? bus.b_we    : bus.m_we;
  assign sel_addr  = sel_b ? bus.b_addr  : bus.m_addr;
  assign sel_wdata = sel_b ? bus.b_wdata : bus.m_wdata;
  assign sel_be    = sel_b ? bus.b_be    : bus.m_be;
  assign sel_oob   = word_oob(sel_addr, DM_WORDS);

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (|gnt) state_d = ISSUE;
      ISSUE:   state_d = (oob_q || dm_we_q) ? RESP : WAIT;
      WAIT:    if (cnt_q == '0) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // outputs decoded from state
  always_comb begin
    m_done = 1'b0;
    b_done = 1'b0;
    oob    = 1'b0;
    busy   = (state_q != IDLE);
    if (state_q == RESP) begin
      m_done = (owner_q == OWN_M);
      b_done = (owner_q == OWN_B);
      oob    = oob_q;
    end
  end

  // Request latch doubles as the registered DM port. Read data lands in the
  // owner's rdata register on entry to RESP so it is valid alongside done.
  // Every in-range read passes through WAIT (cnt starts at MEM_LAT-1), which
  // for MEM_LAT==1 gives the single capture cycle after ISSUE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner_q    <= OWN_M;
      last_q     <= OWN_B;
      oob_q      <= 1'b0;
      cnt_q      <= '0;
      m_rdata_q  <= '0;
      b_rdata_q  <= '0;
      dm_en_q    <= 1'b0;
      dm_we_q    <= 1'b0;
      dm_addr_q  <= '0;
      dm_wdata_q <= '0;
      dm_be_q    <= '0;
    end else begin
      dm_en_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (|gnt) begin
            owner_q    <= sel_b ? OWN_B : OWN_M;
            oob_q      <= sel_oob;
            dm_en_q    <= ~sel_oob;
            dm_we_q    <= sel_we;
            dm_addr_q  <= sel_addr;
            dm_wdata_q <= sel_wdata;
            dm_be_q    <= sel_be;
          end
        end
        ISSUE: begin
          if (!dm_we_q) begin
            if (oob_q) begin
              if (owner_q == OWN_M) m_rdata_q <= '0;
              else                  b_rdata_q <= '0;
            end else begin
              cnt_q <= 4'(MEM_LAT - 1);
            end
          end
        end
        WAIT: begin
          if (cnt_q == '0) begin
            if (owner_q == OWN_M) m_rdata_q <= bus.dm_rdata;
            else                  b_rdata_q <= bus.dm_rdata;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        RESP:    last_q <= owner_q;
        default: ;
      endcase
    end
  end

  assign bus.m_done   = m_done;
  assign bus.b_done   = b_done;
  assign bus.oob      = oob;
  assign bus.busy     = busy;
  assign bus.m_stall  = bus.m_req & ~m_done;
  assign bus.m_rdata  = m_rdata_q;
  assign bus.b_rdata  = b_rdata_q;
  assign bus.dm_en    = dm_en_q;
  assign bus.dm_we    = dm_we_q;
  assign bus.dm_addr  = dm_addr_q;
  assign bus.dm_wdata = dm_wdata_q;
  assign bus.dm_be    = dm_be_q;

endmodule
